// File: rtl/char_t.sv
// char_t: serial character transmitter with a small input FIFO.
// Frame = start bit (0), eight data bits MSB first, stop bit (1); each bit
// lasts div clk cycles, with div sampled once at the start of every frame.
module char_t #(
   parameter int unsigned DIV_W = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DIV_W-1:0]        div,
   input  logic [7:0]              in_char,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    tx,
   output logic                    busy,
   output logic                    done,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int unsigned     AW    = $clog2(DEPTH);
   localparam logic [AW:0]     FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]     LV1   = (AW+1)'(1);
   localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;

   logic             push, pop, last_cyc, fifo_nonempty;
   logic [DIV_W-1:0] div_eff;

   assign push          = in_valid && (level_q != FULL);
   assign fifo_nonempty = (level_q != '0);
   assign last_cyc      = (cnt_q == div_q - ONE_D);
   assign div_eff       = (div == '0) ? ONE_D : div;

   // FIFO occupancy: simultaneous push and pop cancel out
   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LV1;
      end else if (!push && pop) begin
         level_d = level_q - LV1;
      end
   end

   // FIFO storage (no reset needed, contents qualified by level)
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_char;
      end
   end

   // State, counters, shift register, line register and FIFO pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         div_q     <= ONE_D;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         level_q   <= level_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Next-state logic; the value of tx for the coming cycle is decided here
   // so that the line itself is a plain register
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               div_d   = div_eff;
               cnt_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (last_cyc) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               tx_d      = shift_q[7];
               shift_d   = {shift_q[6:0], 1'b0};
               state_d   = DATA;
            end else begin
               cnt_d = cnt_q + ONE_D;
            end
         end
         DATA: begin
            if (last_cyc) begin
               cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[7];
                  shift_d   = {shift_q[6:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + ONE_D;
            end
         end
         STOP: begin
            if (last_cyc) begin
               cnt_d = '0;
               // chain straight into the next start bit when data is waiting
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  div_d   = div_eff;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + ONE_D;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // Outputs derived from registered state
   always_comb begin
      tx       = tx_q;
      level    = level_q;
      in_ready = (level_q != FULL);
      busy     = (state_q != IDLE) || fifo_nonempty;
      done     = (state_q == STOP) && last_cyc;
   end

endmodule

// File: tb/tb_char_t.sv
// tb_char_t: directed self-checking bench for char_t.
module tb_char_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] div = 16'd4;
   logic [7:0]  in_char = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready, tx, busy, done;
   logic [2:0]  level;

   int errors = 0;
   int checks = 0;

   char_t #(.DIV_W(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .div(div), .in_char(in_char), .in_valid(in_valid),
      .in_ready(in_ready), .tx(tx), .busy(busy), .done(done), .level(level)
   );

   always #5 clk = ~clk;

   // done pulse counter
   int done_cnt = 0;
   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   // reference line receiver for the loopback scenario
   logic       rx_en = 1'b0;
   int         rx_div = 4;
   logic       rx_busy;
   int         rx_cyc;
   int         rx_n;
   logic       rx_ferr;
   logic [7:0] rx_sh;
   logic [7:0] rx_chars [8];
   always @(posedge clk) begin
      if (!rx_en) begin
         rx_busy <= 1'b0; rx_cyc <= 0; rx_n <= 0; rx_ferr <= 1'b0;
      end else if (!rx_busy) begin
         if (tx === 1'b0) begin rx_busy <= 1'b1; rx_cyc <= 1; end
      end else begin
         for (int j = 0; j < 8; j++)
            if (rx_cyc == (1 + j) * rx_div + rx_div / 2) rx_sh[7 - j] <= tx;
         if (rx_cyc == 9 * rx_div + rx_div / 2) begin
            rx_busy <= 1'b0;
            if (tx !== 1'b1) rx_ferr <= 1'b1;
            if (rx_n < 8) rx_chars[rx_n] <= rx_sh;
            rx_n <= rx_n + 1;
         end
         rx_cyc <= rx_cyc + 1;
      end
   end

   // expected line level for frame bit k (0 = start, 1..8 = data MSB first, 9 = stop)
   function automatic logic exp_bit(input logic [7:0] ch, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return ch[8 - k];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      logic [7:0] ch = 8'h41;
      div = 16'd4;
      in_char = ch; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level1: got %0d expected 1", level); end
      step();
      for (int i = 0; i < 40; i++) begin
         checks++;
         if (tx !== exp_bit(ch, i / 4)) begin errors++; $display("FAIL single_tx[%0d]: got %b expected %b", i, tx, exp_bit(ch, i / 4)); end
         checks++;
         if (done !== (i == 39)) begin errors++; $display("FAIL single_done[%0d]: got %b expected %b", i, done, (i == 39)); end
         step();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_end: got %0d expected 0", level); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_idle: got %b expected 1", tx); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] chs [3] = '{8'h55, 8'hAA, 8'hFF};
      int d0 = done_cnt;
      logic e;
      div = 16'd2;
      in_valid = 1'b1;
      in_char = chs[0]; step();
      in_char = chs[1]; step();
      in_char = chs[2]; step();
      in_valid = 1'b0;
      for (int i = 1; i < 60; i++) begin
         e = exp_bit(chs[i / 20], (i % 20) / 2);
         checks++;
         if (tx !== e) begin errors++; $display("FAIL b2b_tx[%0d]: got %b expected %b", i, tx, e); end
         checks++;
         if (done !== ((i % 20) == 19)) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", i, done, ((i % 20) == 19)); end
         step();
      end
      checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_full_fifo();
      logic e;
      div = 16'd8;
      in_valid = 1'b1;
      in_char = 8'h30;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (in_ready !== (i <= 4)) begin errors++; $display("FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, (i <= 4)); end
         step();
         if (i == 7) in_valid = 1'b0;
         else in_char = 8'h31 + 8'(i);
      end
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level_peak: got %0d expected 4", level); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_low: got %b expected 0", in_ready); end
      // sample point here is cycle 6 of the first frame
      for (int c = 6; c < 400; c++) begin
         e = exp_bit(8'h30 + 8'(c / 80), (c % 80) / 8);
         checks++;
         if (tx !== e) begin errors++; $display("FAIL full_tx[%0d]: got %b expected %b", c, tx, e); end
         step();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b expected 0", busy); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL full_level_end: got %0d expected 0", level); end
   endtask

   task automatic test_div_edges();
      logic [7:0] ch0 = 8'h5A;
      logic [7:0] ch1 = 8'hC3;
      logic e;
      // div = 0 behaves as 1
      div = 16'd0;
      in_char = 8'h80; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (tx !== exp_bit(8'h80, i)) begin errors++; $display("FAIL div0_tx[%0d]: got %b expected %b", i, tx, exp_bit(8'h80, i)); end
         checks++;
         if (done !== (i == 9)) begin errors++; $display("FAIL div0_done[%0d]: got %b expected %b", i, done, (i == 9)); end
         step();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div0_busy_end: got %b expected 0", busy); end
      // divisor change mid-frame
      div = 16'd3;
      in_valid = 1'b1;
      in_char = ch0; step();
      in_char = ch1; step();
      in_valid = 1'b0;
      for (int i = 0; i < 90; i++) begin
         if (i == 5) div = 16'd6;
         e = (i < 30) ? exp_bit(ch0, i / 3) : exp_bit(ch1, (i - 30) / 6);
         checks++;
         if (tx !== e) begin errors++; $display("FAIL divchg_tx[%0d]: got %b expected %b", i, tx, e); end
         checks++;
         if (done !== (i == 29 || i == 89)) begin errors++; $display("FAIL divchg_done[%0d]: got %b expected %b", i, done, (i == 29 || i == 89)); end
         step();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divchg_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] ch = 8'h3C;
      div = 16'd4;
      in_valid = 1'b1;
      in_char = ch;    step();
      in_char = 8'h11; step();
      in_char = 8'h22; step();
      in_valid = 1'b0;
      for (int i = 1; i < 17; i++) begin
         checks++;
         if (tx !== exp_bit(ch, i / 4)) begin errors++; $display("FAIL rstmid_tx[%0d]: got %b expected %b", i, tx, exp_bit(ch, i / 4)); end
         step();
      end
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL rstmid_level_pre: got %0d expected 2", level); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", level); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
      step();
      ch = 8'h96;
      in_char = ch; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      for (int i = 0; i < 40; i++) begin
         checks++;
         if (tx !== exp_bit(ch, i / 4)) begin errors++; $display("FAIL rstpost_tx[%0d]: got %b expected %b", i, tx, exp_bit(ch, i / 4)); end
         step();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstpost_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_loopback();
      logic [7:0] msg [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      int d0;
      int budget;
      logic acc;
      div = 16'd4;
      rx_div = 4;
      rx_en = 1'b1;
      step();
      d0 = done_cnt;
      for (int k = 0; k < 5; k++) begin
         in_char = msg[k]; in_valid = 1'b1;
         acc = 1'b0; budget = 0;
         while (!acc && budget < 200) begin
            acc = in_ready;
            step();
            budget++;
         end
         checks++;
         if (!acc) begin errors++; $display("FAIL loop_push[%0d]: got not accepted expected accepted", k); end
      end
      in_valid = 1'b0;
      budget = 0;
      while (rx_n < 5 && budget < 1000) begin step(); budget++; end
      checks++; if (rx_n != 5) begin errors++; $display("FAIL loop_rx_count: got %0d expected 5", rx_n); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (rx_chars[k] !== msg[k]) begin errors++; $display("FAIL loop_char[%0d]: got %02h expected %02h", k, rx_chars[k], msg[k]); end
      end
      checks++; if (rx_ferr !== 1'b0) begin errors++; $display("FAIL loop_stop_bit: got framing error expected none"); end
      budget = 0;
      while (busy && budget < 100) begin step(); budget++; end
      checks++; if (done_cnt - d0 !== 5) begin errors++; $display("FAIL loop_done_count: got %0d expected 5", done_cnt - d0); end
      rx_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full_fifo();
      test_div_edges();
      test_reset_midframe();
      test_loopback();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
